// File: rtl/spi_word_serializer.sv
// spi_word_serializer: pulls words from the tx buffer and streams them MSB byte first to the SPI byte driver
module spi_word_serializer #(
    parameter int         DATA_WIDTH = 32,
    parameter int         ATTR_WIDTH = 4,
    parameter int         INVALID    = 0,
    parameter logic [7:0] FILL_BYTE  = 8'h00,
    parameter int         CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  buf_oe,
    input  logic [DATA_WIDTH-1:0] buf_data,
    input  logic [ATTR_WIDTH-1:0] buf_attr,
    input  logic                  frame_active,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  words_sent
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW = BYTES > 1 ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, FILL} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         cnt;
    logic                  hs;
    logic                  empty;
    logic                  last;
    logic                  unused_attr;

    assign empty       = buf_attr[INVALID];
    assign last        = cnt == BW'(BYTES - 1);
    assign unused_attr = ^buf_attr;

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    // next state and Moore outputs; a dropped frame wins over any handshake in the same cycle
    always_comb begin
        state_nx   = state;
        buf_oe     = 1'b0;
        byte_valid = 1'b0;
        byte_out   = '0;
        hs         = 1'b0;
        case (state)
            IDLE: state_nx = !frame_active ? IDLE : empty ? FILL : FETCH;
            FETCH: begin
                buf_oe   = 1'b1;
                state_nx = !frame_active ? IDLE : empty ? FILL : SEND;
            end
            SEND: begin
                byte_valid = 1'b1;
                byte_out   = shreg[DATA_WIDTH-1 -: 8];
                hs         = byte_ready & frame_active;
                state_nx   = !frame_active ? IDLE : (hs && last) ? (empty ? FILL : FETCH) : SEND;
            end
            FILL: begin
                byte_valid = 1'b1;
                byte_out   = FILL_BYTE;
                hs         = byte_ready & frame_active;
                state_nx   = !frame_active ? IDLE : hs ? (empty ? FILL : FETCH) : FILL;
            end
            default: state_nx = IDLE;
        endcase
    end

    // word capture, byte shifting, word counting and underrun pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            cnt        <= '0;
            words_sent <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= state == FILL && hs;
            if (state == FETCH && !empty) begin
                shreg <= buf_data;
                cnt   <= '0;
            end else if (state == SEND && hs) begin
                shreg <= shreg << 8;
                cnt   <= cnt + 1'b1;
                if (last)
                    words_sent <= words_sent + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_word_serializer.sv
// tb_spi_word_serializer: scenario tasks against a queue-based buffer and byte-stream reference model
module tb_spi_word_serializer;
    localparam int BYTES = 4;
    localparam logic [7:0] FILL = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        buf_oe;
    logic [31:0] buf_data;
    logic [3:0]  buf_attr;
    logic        frame_active = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        underrun;
    logic [15:0] words_sent;

    logic [31:0] bq[$];
    logic [7:0]  got[$];
    int          got_t[$];
    int          cyc, oe_cnt, oe_dbl, stall_err, und_cnt;
    bit          oe_pop, oe_last, stall_prev;
    logic [7:0]  held;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] ws_exp = '0;

    always #5 clk = ~clk;

    spi_word_serializer dut (
        .clk(clk), .rst(rst), .buf_oe(buf_oe), .buf_data(buf_data), .buf_attr(buf_attr),
        .frame_active(frame_active), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .underrun(underrun), .words_sent(words_sent)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] byte_of(logic [31:0] w, int i);
        return 8'((w >> (8 * (BYTES - 1 - i))) & 32'hFF);
    endfunction

    function automatic logic [7:0] gb(int i);
        return i < got.size() ? got[i] : 8'hxx;
    endfunction

    task automatic refresh();
        buf_data = bq.size() != 0 ? bq[0] : '0;
        buf_attr = bq.size() != 0 ? 4'b0000 : 4'b0001;
    endtask

    task automatic push(logic [31:0] w);
        bq.push_back(w);
        refresh();
    endtask

    task automatic clear();
        got.delete();
        got_t.delete();
        oe_cnt = 0;
        und_cnt = 0;
        stall_err = 0;
    endtask

    // one clock: observe mid-cycle (buffer pop, handshakes, stalls), then return 1 time unit after the edge
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            cyc++;
            if (oe_pop) begin
                void'(bq.pop_front());
                refresh();
            end
            oe_pop = buf_oe && !buf_attr[0];
            if (buf_oe) oe_cnt++;
            if (buf_oe && oe_last) oe_dbl++;
            oe_last = buf_oe;
            if (stall_prev && (!byte_valid || byte_out !== held)) stall_err++;
            stall_prev = byte_valid && !byte_ready && frame_active;
            held = byte_out;
            if (byte_valid && byte_ready && frame_active) begin
                got.push_back(byte_out);
                got_t.push_back(cyc);
            end
            if (underrun) und_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        frame_active = 1'b0;
        byte_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_active = 1'b1;
        byte_ready = 1'b1;
        push(32'hA1B2C3D4);
        tick();
        tick();
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", byte_valid); end
        checks++; if (buf_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", buf_oe); end
        checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL reset_words got=%0d exp=0", words_sent); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte got=%h exp=00", byte_out); end
        checks++; if (bq.size() != 1) begin errors++; $display("FAIL reset_buffer got=%0d exp=1", bq.size()); end
        rst = 1'b0;
        frame_active = 1'b0;
        tick();
        checks++; if (buf_oe !== 1'b0) begin errors++; $display("FAIL reset_idle_oe got=%b exp=0", buf_oe); end
    endtask

    task automatic test_single();
        clear();
        byte_ready = 1'b1;
        frame_active = 1'b1;
        tick();
        checks++; if (buf_oe !== 1'b1) begin errors++; $display("FAIL single_fetch_oe got=%b exp=1", buf_oe); end
        tick();
        checks++; if (byte_valid !== 1'b1 || byte_out !== 8'hA1) begin errors++; $display("FAIL single_first got=%b/%h exp=1/a1", byte_valid, byte_out); end
        repeat (8) tick();
        settle();
        ws_exp += 16'd1;
        checks++; if (got.size() != 8) begin errors++; $display("FAIL single_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            e = i < 4 ? byte_of(32'hA1B2C3D4, i) : FILL;
            checks++; if (gb(i) !== e) begin errors++; $display("FAIL single_byte%0d got=%h exp=%h", i, gb(i), e); end
        end
        checks++; if (und_cnt != 4) begin errors++; $display("FAIL single_underrun got=%0d exp=4", und_cnt); end
        checks++; if (oe_cnt != 1) begin errors++; $display("FAIL single_oe got=%0d exp=1", oe_cnt); end
        checks++; if (words_sent !== ws_exp) begin errors++; $display("FAIL single_words got=%0d exp=%0d", words_sent, ws_exp); end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int bad;
        pat = 4'b1001;
        clear();
        push(32'h11223344);
        frame_active = 1'b1;
        for (int k = 0; k < 24; k++) begin
            byte_ready = pat[3 - (k % 4)];
            tick();
        end
        settle();
        ws_exp += 16'd1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (gb(i) !== byte_of(32'h11223344, i)) begin errors++; $display("FAIL bp_byte%0d got=%h exp=%h", i, gb(i), byte_of(32'h11223344, i)); end
        end
        bad = 0;
        for (int i = 4; i < got.size(); i++) if (got[i] !== FILL) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_tail got=%0d non-fill bytes exp=0", bad); end
        checks++; if (und_cnt != got.size() - 4) begin errors++; $display("FAIL bp_underrun got=%0d exp=%0d", und_cnt, got.size() - 4); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable got=%0d unstable stalls exp=0", stall_err); end
        checks++; if (oe_cnt != 1) begin errors++; $display("FAIL bp_oe got=%0d exp=1", oe_cnt); end
        checks++; if (words_sent !== ws_exp) begin errors++; $display("FAIL bp_words got=%0d exp=%0d", words_sent, ws_exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[3];
        w[0] = 32'h01020304; w[1] = 32'h05060708; w[2] = 32'h090A0B0C;
        clear();
        for (int i = 0; i < 3; i++) push(w[i]);
        byte_ready = 1'b1;
        frame_active = 1'b1;
        for (int k = 0; k < 40 && got.size() < 12; k++) tick();
        settle();
        ws_exp += 16'd3;
        checks++; if (got.size() != 12) begin errors++; $display("FAIL b2b_count got=%0d exp=12", got.size()); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (gb(i) !== byte_of(w[i / 4], i % 4)) begin errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, gb(i), byte_of(w[i / 4], i % 4)); end
        end
        for (int i = 1; i < 12 && i < got_t.size(); i++) begin
            checks++; if (got_t[i] - got_t[0] != i + i / 4) begin errors++; $display("FAIL b2b_timing%0d got=%0d exp=%0d", i, got_t[i] - got_t[0], i + i / 4); end
        end
        checks++; if (oe_cnt != 3) begin errors++; $display("FAIL b2b_oe got=%0d exp=3", oe_cnt); end
        checks++; if (words_sent !== ws_exp) begin errors++; $display("FAIL b2b_words got=%0d exp=%0d", words_sent, ws_exp); end
    endtask

    task automatic test_empty_fill();
        int k, bad;
        clear();
        byte_ready = 1'b1;
        frame_active = 1'b1;
        repeat (5) tick();
        push(32'hDEADBEEF);
        repeat (12) tick();
        settle();
        ws_exp += 16'd1;
        k = 0;
        while (k < got.size() && got[k] === FILL) k++;
        checks++; if (k < 1) begin errors++; $display("FAIL fill_lead got=%0d fill bytes exp>=1", k); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (gb(k + i) !== byte_of(32'hDEADBEEF, i)) begin errors++; $display("FAIL fill_byte%0d got=%h exp=%h", i, gb(k + i), byte_of(32'hDEADBEEF, i)); end
        end
        bad = 0;
        for (int i = k + 4; i < got.size(); i++) if (got[i] !== FILL) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL fill_tail got=%0d non-fill bytes exp=0", bad); end
        checks++; if (und_cnt != got.size() - 4) begin errors++; $display("FAIL fill_underrun got=%0d exp=%0d", und_cnt, got.size() - 4); end
        checks++; if (words_sent !== ws_exp) begin errors++; $display("FAIL fill_words got=%0d exp=%0d", words_sent, ws_exp); end
    endtask

    task automatic test_abort();
        clear();
        push(32'hCAFEF00D);
        push(32'h12345678);
        byte_ready = 1'b1;
        frame_active = 1'b1;
        for (int k = 0; k < 20 && got.size() < 2; k++) tick();
        frame_active = 1'b0;
        tick();
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b exp=0", byte_valid); end
        repeat (3) tick();
        checks++; if (got.size() != 2) begin errors++; $display("FAIL abort_count got=%0d exp=2", got.size()); end
        checks++; if (gb(0) !== 8'hCA || gb(1) !== 8'hFE) begin errors++; $display("FAIL abort_bytes got=%h%h exp=cafe", gb(0), gb(1)); end
        checks++; if (words_sent !== ws_exp) begin errors++; $display("FAIL abort_words got=%0d exp=%0d", words_sent, ws_exp); end
        checks++; if (oe_cnt != 1) begin errors++; $display("FAIL abort_oe got=%0d exp=1", oe_cnt); end
        checks++; if (bq.size() != 1) begin errors++; $display("FAIL abort_buffer got=%0d exp=1", bq.size()); end
        clear();
        frame_active = 1'b1;
        repeat (10) tick();
        settle();
        ws_exp += 16'd1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (gb(i) !== byte_of(32'h12345678, i)) begin errors++; $display("FAIL abort_next%0d got=%h exp=%h", i, gb(i), byte_of(32'h12345678, i)); end
        end
        checks++; if (words_sent !== ws_exp) begin errors++; $display("FAIL abort_next_words got=%0d exp=%0d", words_sent, ws_exp); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] exp_b[$];
            int n, bad;
            logic [31:0] w;
            clear();
            n = 1 + int'($urandom % 4);
            for (int j = 0; j < n; j++) begin
                w = $urandom;
                push(w);
                for (int i = 0; i < BYTES; i++) exp_b.push_back(byte_of(w, i));
            end
            frame_active = 1'b1;
            for (int k = 0; k < 300 && got.size() < 4 * n; k++) begin
                byte_ready = $urandom % 2 == 1;
                tick();
            end
            settle();
            ws_exp += 16'(n);
            bad = 0;
            for (int i = 0; i < exp_b.size(); i++) if (gb(i) !== exp_b[i]) bad++;
            checks++; if (got.size() != 4 * n) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, got.size(), 4 * n); end
            checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_bytes got=%0d wrong bytes exp=0", it, bad); end
            checks++; if (words_sent !== ws_exp) begin errors++; $display("FAIL rand%0d_words got=%0d exp=%0d", it, words_sent, ws_exp); end
            checks++; if (oe_cnt != n) begin errors++; $display("FAIL rand%0d_oe got=%0d exp=%0d", it, oe_cnt, n); end
            checks++; if (stall_err != 0) begin errors++; $display("FAIL rand%0d_stable got=%0d exp=0", it, stall_err); end
            checks++; if (und_cnt != 0) begin errors++; $display("FAIL rand%0d_underrun got=%0d exp=0", it, und_cnt); end
        end
        checks++; if (oe_dbl != 0) begin errors++; $display("FAIL oe_consecutive got=%0d exp=0", oe_dbl); end
    endtask

    initial begin
        refresh();
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_empty_fill();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
